// File: rtl/led_sched_funcmod_pkg.sv
// Mode/speed codes, default step periods and pattern start values for the LED scheduler.
package led_sched_funcmod_pkg;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] SPEED_1S    = 2'd0;
    localparam logic [1:0] SPEED_100MS = 2'd1;
    localparam logic [1:0] SPEED_10MS  = 2'd2;
    localparam logic [1:0] SPEED_1MS   = 2'd3;

    localparam logic [25:0] T1S_DEF    = 26'd50_000_000;
    localparam logic [25:0] T100MS_DEF = 26'd5_000_000;
    localparam logic [25:0] T10MS_DEF  = 26'd500_000;
    localparam logic [25:0] T1MS_DEF   = 26'd50_000;

    localparam logic [3:0] LED_START_SHL   = 4'b0001;
    localparam logic [3:0] LED_START_SHR   = 4'b1000;
    localparam logic [3:0] LED_START_PING  = 4'b0001;
    localparam logic [3:0] LED_START_BLINK = 4'b1111;

    function automatic logic [3:0] start_led(input mode_e mode);
        logic [3:0] val;
        unique case (mode)
            MODE_SHL:   val = LED_START_SHL;
            MODE_SHR:   val = LED_START_SHR;
            MODE_PING:  val = LED_START_PING;
            MODE_BLINK: val = LED_START_BLINK;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/led_tick_funcmod.sv
// Step timebase: counts 0..T-1 and flags the terminal count; Clr restarts the step.
module led_tick_funcmod (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [25:0] T,
    input  logic        Clr,
    output logic        TC
);

    logic [25:0] c1_q;

    assign TC = (c1_q == T - 26'd1);

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            c1_q <= '0;
        end else if (Clr || TC) begin
            c1_q <= '0;
        end else begin
            c1_q <= c1_q + 26'd1;
        end
    end

endmodule

// File: rtl/led_sched_funcmod.sv
// Two-requester round-robin command scheduler driving the 4-LED flowing-light pattern.
module led_sched_funcmod
    import led_sched_funcmod_pkg::*;
#(
    parameter logic [25:0] T1S    = T1S_DEF,
    parameter logic [25:0] T100MS = T100MS_DEF,
    parameter logic [25:0] T10MS  = T10MS_DEF,
    parameter logic [25:0] T1MS   = T1MS_DEF
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       Req_A,
    input  logic [1:0] Mode_A,
    input  logic [1:0] Speed_A,
    output logic       Ack_A,
    input  logic       Req_B,
    input  logic [1:0] Mode_B,
    input  logic [1:0] Speed_B,
    output logic       Ack_B,
    output logic [3:0] LED,
    output logic [1:0] Mode_Q,
    output logic [1:0] Speed_Q,
    output logic       Pend
);

    mode_e       mode_q, mode_d;
    mode_e       pend_mode_q, pend_mode_d;
    dir_e        dir_q, dir_d;
    logic [1:0]  speed_q, speed_d;
    logic [1:0]  pend_speed_q, pend_speed_d;
    logic [3:0]  led_q, led_d;
    logic        pend_q, pend_d;
    logic        ack_a_q, ack_b_q;
    logic        prefer_b_q, prefer_b_d;
    logic        grant_a, grant_b, apply, tc;
    logic [25:0] t_sel;

    always_comb begin
        t_sel = T1S;
        unique case (speed_q)
            SPEED_1S:    t_sel = T1S;
            SPEED_100MS: t_sel = T100MS;
            SPEED_10MS:  t_sel = T10MS;
            SPEED_1MS:   t_sel = T1MS;
        endcase
    end

    led_tick_funcmod u_tick (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .T     (t_sel),
        .Clr   (apply),
        .TC    (tc)
    );

    // Both requesting: the one not granted last wins.
    assign grant_a = !pend_q && Req_A && (!Req_B || !prefer_b_q);
    assign grant_b = !pend_q && Req_B && (!Req_A || prefer_b_q);
    assign apply   = tc && pend_q;

    always_comb begin
        mode_d       = mode_q;
        speed_d      = speed_q;
        led_d        = led_q;
        dir_d        = dir_q;
        pend_d       = pend_q;
        pend_mode_d  = pend_mode_q;
        pend_speed_d = pend_speed_q;
        prefer_b_d   = prefer_b_q;

        if (grant_a) begin
            pend_d       = 1'b1;
            pend_mode_d  = mode_e'(Mode_A);
            pend_speed_d = Speed_A;
            prefer_b_d   = 1'b1;
        end else if (grant_b) begin
            pend_d       = 1'b1;
            pend_mode_d  = mode_e'(Mode_B);
            pend_speed_d = Speed_B;
            prefer_b_d   = 1'b0;
        end

        // Applying a command replaces the pattern advance on this terminal count.
        if (apply) begin
            mode_d  = pend_mode_q;
            speed_d = pend_speed_q;
            led_d   = start_led(pend_mode_q);
            dir_d   = DIR_UP;
            pend_d  = 1'b0;
        end else if (tc) begin
            unique case (mode_q)
                MODE_SHL:   led_d = {led_q[2:0], led_q[3]};
                MODE_SHR:   led_d = {led_q[0], led_q[3:1]};
                MODE_PING: begin
                    if (dir_q == DIR_UP) begin
                        if (led_q[3]) begin
                            led_d = 4'b0100;
                            dir_d = DIR_DOWN;
                        end else begin
                            led_d = led_q << 1;
                        end
                    end else begin
                        if (led_q[0]) begin
                            led_d = 4'b0010;
                            dir_d = DIR_UP;
                        end else begin
                            led_d = led_q >> 1;
                        end
                    end
                end
                MODE_BLINK: led_d = ~led_q;
            endcase
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            mode_q       <= MODE_SHL;
            speed_q      <= SPEED_1S;
            led_q        <= LED_START_SHL;
            dir_q        <= DIR_UP;
            pend_q       <= 1'b0;
            pend_mode_q  <= MODE_SHL;
            pend_speed_q <= SPEED_1S;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            prefer_b_q   <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            speed_q      <= speed_d;
            led_q        <= led_d;
            dir_q        <= dir_d;
            pend_q       <= pend_d;
            pend_mode_q  <= pend_mode_d;
            pend_speed_q <= pend_speed_d;
            ack_a_q      <= grant_a;
            ack_b_q      <= grant_b;
            prefer_b_q   <= prefer_b_d;
        end
    end

    assign Ack_A   = ack_a_q;
    assign Ack_B   = ack_b_q;
    assign LED     = led_q;
    assign Mode_Q  = mode_q;
    assign Speed_Q = speed_q;
    assign Pend    = pend_q;

endmodule

// File: tb/tb_led_sched_funcmod.sv
// Self-checking bench for led_sched_funcmod with shortened step periods (8/4/2/1 cycles).
module tb_led_sched_funcmod;

    logic       CLOCK;
    logic       RESET;
    logic       Req_A, Req_B;
    logic [1:0] Mode_A, Speed_A, Mode_B, Speed_B;
    logic       Ack_A, Ack_B;
    logic [3:0] LED;
    logic [1:0] Mode_Q, Speed_Q;
    logic       Pend;

    int checks = 0;
    int errors = 0;

    led_sched_funcmod #(
        .T1S    (26'd8),
        .T100MS (26'd4),
        .T10MS  (26'd2),
        .T1MS   (26'd1)
    ) dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .Req_A   (Req_A),
        .Mode_A  (Mode_A),
        .Speed_A (Speed_A),
        .Ack_A   (Ack_A),
        .Req_B   (Req_B),
        .Mode_B  (Mode_B),
        .Speed_B (Speed_B),
        .Ack_B   (Ack_B),
        .LED     (LED),
        .Mode_Q  (Mode_Q),
        .Speed_Q (Speed_Q),
        .Pend    (Pend)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    // Directed vectors: one command from A after reset, then seven LED values after apply.
    typedef struct {
        logic [1:0]  mode;
        logic [1:0]  speed;
        int          period;
        logic [27:0] seq;
    } vec_t;

    vec_t vecs [5];

    // Reference model: patterns as plain value tables indexed by step number.
    int         per [4]       = '{8, 4, 2, 1};
    logic [3:0] pat_shl [4]   = '{4'h1, 4'h2, 4'h4, 4'h8};
    logic [3:0] pat_shr [4]   = '{4'h8, 4'h4, 4'h2, 4'h1};
    logic [3:0] pat_ping [6]  = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2};
    logic [3:0] pat_blink [2] = '{4'hF, 4'h0};

    logic [1:0] m_mode, m_speed, m_pmode, m_pspeed;
    int         m_idx, m_elapsed;
    bit         m_pend, m_acka, m_ackb, m_last_a;

    function automatic logic [3:0] pat_val(input logic [1:0] mode, input int idx);
        case (mode)
            2'd0:    return pat_shl[idx];
            2'd1:    return pat_shr[idx];
            2'd2:    return pat_ping[idx];
            default: return pat_blink[idx];
        endcase
    endfunction

    function automatic int pat_len(input logic [1:0] mode);
        case (mode)
            2'd2:    return 6;
            2'd3:    return 2;
            default: return 4;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = 0; m_speed = 0; m_pmode = 0; m_pspeed = 0;
        m_idx = 0; m_elapsed = 0;
        m_pend = 0; m_acka = 0; m_ackb = 0; m_last_a = 0;
    endtask

    task automatic model_step();
        bit tc, ga, gb;
        tc = (m_elapsed == per[m_speed] - 1);
        ga = 0;
        gb = 0;
        if (!m_pend) begin
            if (Req_A && Req_B) begin
                if (m_last_a) gb = 1; else ga = 1;
            end else if (Req_A) ga = 1;
            else if (Req_B) gb = 1;
        end
        m_acka = ga;
        m_ackb = gb;
        if (m_pend && tc) begin
            m_mode = m_pmode; m_speed = m_pspeed;
            m_idx = 0; m_elapsed = 0; m_pend = 0;
        end else if (tc) begin
            m_idx = (m_idx + 1) % pat_len(m_mode);
            m_elapsed = 0;
        end else begin
            m_elapsed++;
        end
        if (ga) begin m_pend = 1; m_pmode = Mode_A; m_pspeed = Speed_A; m_last_a = 1; end
        if (gb) begin m_pend = 1; m_pmode = Mode_B; m_pspeed = Speed_B; m_last_a = 0; end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b0;
        Req_A = 0; Mode_A = 0; Speed_A = 0;
        Req_B = 0; Mode_B = 0; Speed_B = 0;
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
    endtask

    initial begin
        bit prev_a, prev_b;
        logic [9:0] act_v, exp_v;

        vecs[0] = '{mode: 2'd0, speed: 2'd1, period: 4, seq: 28'h1248124};
        vecs[1] = '{mode: 2'd1, speed: 2'd2, period: 2, seq: 28'h8421842};
        vecs[2] = '{mode: 2'd2, speed: 2'd1, period: 4, seq: 28'h1248421};
        vecs[3] = '{mode: 2'd3, speed: 2'd3, period: 1, seq: 28'hF0F0F0F};
        vecs[4] = '{mode: 2'd2, speed: 2'd0, period: 8, seq: 28'h1248421};

        // Idle after reset: default shift-left at 8 cycles per step.
        apply_reset();
        check("rst_led", LED, 4'h1);
        check("rst_mode", Mode_Q, 2'd0);
        check("rst_speed", Speed_Q, 2'd0);
        check("rst_pend", Pend, 1'b0);
        check("rst_ack", {Ack_A, Ack_B}, 2'b00);
        begin
            logic [23:0] idle_seq;
            idle_seq = 24'h124812;
            for (int k = 1; k < 6; k++) begin
                repeat (7) tick();
                check("idle_hold", LED, idle_seq[(6 - k) * 4 +: 4]);
                tick();
                check("idle_step", LED, idle_seq[(5 - k) * 4 +: 4]);
            end
        end

        // Table-driven single commands from A.
        for (int v = 0; v < 5; v++) begin
            apply_reset();
            Req_A = 1; Mode_A = vecs[v].mode; Speed_A = vecs[v].speed;
            tick();
            check("vec_ack", {Ack_A, Ack_B, Pend}, 3'b101);
            tick();
            check("vec_ack_end", Ack_A, 1'b0);
            Req_A = 0;
            repeat (5) tick();
            check("vec_wait", {LED, Pend}, {4'h1, 1'b1});
            tick();
            check("vec_apply", {LED, Mode_Q, Speed_Q, Pend},
                  {vecs[v].seq[27:24], vecs[v].mode, vecs[v].speed, 1'b0});
            for (int k = 1; k < 7; k++) begin
                repeat (vecs[v].period - 1) tick();
                check("vec_hold", LED, vecs[v].seq[(7 - k) * 4 +: 4]);
                tick();
                check("vec_step", LED, vecs[v].seq[(6 - k) * 4 +: 4]);
            end
        end

        // Simultaneous requests: A first, B granted the cycle after A applies.
        apply_reset();
        Req_A = 1; Mode_A = 2'd1; Speed_A = 2'd2;
        Req_B = 1; Mode_B = 2'd3; Speed_B = 2'd1;
        tick();
        check("rr_first", {Ack_A, Ack_B}, 2'b10);
        tick();
        Req_A = 0;
        repeat (5) tick();
        check("rr_blocked", {Ack_B, Pend}, 2'b01);
        tick();
        check("rr_a_apply", {Mode_Q, Pend, Ack_B, LED}, {2'd1, 1'b0, 1'b0, 4'h8});
        tick();
        check("rr_b_ack", {Ack_B, Pend, Mode_Q}, {1'b1, 1'b1, 2'd1});
        tick();
        check("rr_b_apply", {Mode_Q, Speed_Q, LED, Pend, Ack_B}, {2'd3, 2'd1, 4'hF, 1'b0, 1'b0});
        Req_B = 0;
        repeat (3) tick();
        check("rr_b_hold", LED, 4'hF);
        tick();
        check("rr_b_step", LED, 4'h0);

        // T=1 blink, then a new command applies on the edge after its grant.
        apply_reset();
        Req_A = 1; Mode_A = 2'd3; Speed_A = 2'd3;
        tick();
        tick();
        Req_A = 0;
        repeat (6) tick();
        check("fast_apply", LED, 4'hF);
        tick();
        check("fast_tog0", LED, 4'h0);
        tick();
        check("fast_tog1", LED, 4'hF);
        Req_A = 1; Mode_A = 2'd1; Speed_A = 2'd3;
        tick();
        check("fast_grant", {Ack_A, Pend, LED}, {1'b1, 1'b1, 4'h0});
        tick();
        check("fast_apply2", {LED, Mode_Q, Pend}, {4'h8, 2'd1, 1'b0});
        Req_A = 0;
        tick();
        check("fast_shr", LED, 4'h4);

        // Async reset mid-step with a pending command.
        apply_reset();
        repeat (10) tick();
        check("ar_pre", LED, 4'h2);
        Req_A = 1; Mode_A = 2'd2; Speed_A = 2'd1;
        tick();
        check("ar_pend", {Ack_A, Pend}, 2'b11);
        #2;
        RESET = 1'b0;
        Req_A = 0;
        #1;
        check("ar_async", {LED, Mode_Q, Speed_Q, Pend, Ack_A, Ack_B},
              {4'h1, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0});
        @(negedge CLOCK);
        RESET = 1'b1;
        repeat (7) tick();
        check("ar_hold", {LED, Pend}, {4'h1, 1'b0});
        tick();
        check("ar_discard", {LED, Mode_Q, Pend}, {4'h2, 2'd0, 1'b0});

        // Identical command restarts the running pattern.
        apply_reset();
        repeat (18) tick();
        check("same_pre", LED, 4'h4);
        Req_B = 1; Mode_B = 2'd0; Speed_B = 2'd0;
        tick();
        check("same_ack", {Ack_B, Pend}, 2'b11);
        tick();
        Req_B = 0;
        repeat (3) tick();
        check("same_wait", {LED, Pend}, {4'h4, 1'b1});
        tick();
        check("same_restart", {LED, Pend}, {4'h1, 1'b0});
        repeat (7) tick();
        check("same_hold", LED, 4'h1);
        tick();
        check("same_step", LED, 4'h2);

        // Randomised requests against the reference model.
        apply_reset();
        model_reset();
        prev_a = 0;
        prev_b = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLOCK);
            model_step();
            #1;
            act_v = {LED, Mode_Q, Speed_Q, Pend, Ack_A, Ack_B};
            exp_v = {pat_val(m_mode, m_idx), m_mode, m_speed, m_pend, m_acka, m_ackb};
            check("rand", act_v, exp_v);
            if (prev_a) Req_A = 0;
            else if (!Req_A && $urandom_range(0, 5) == 0) begin
                Req_A = 1;
                Mode_A = 2'($urandom_range(0, 3));
                Speed_A = 2'($urandom_range(0, 3));
            end
            prev_a = m_acka;
            if (prev_b) Req_B = 0;
            else if (!Req_B && $urandom_range(0, 5) == 0) begin
                Req_B = 1;
                Mode_B = 2'($urandom_range(0, 3));
                Speed_B = 2'($urandom_range(0, 3));
            end
            prev_b = m_ackb;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
